hps_request_arbiter: RTL and testbench

Collects service requests from up to eight FPGA-side requesters, picks one by round-robin and posts it as a 32-bit status word on the `in_port` of the HPS_REQUEST Avalon PIO. Software on the HPS reads that word, services the request, and acknowledges through a single bit of an output PIO. The block runs a four-phase handshake with the HPS, returns a one-cycle completion pulse to the winning requester, and only then accepts the next request.

---
 rtl/hps_req_pkg.sv | 28 ++
 rtl/hps_req_rr_pick.sv | 34 +++
 rtl/hps_request_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_hps_request_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hps_req_pkg.sv
// Shared types and status-word layout for the HPS request arbiter.
// Imported by hps_req_rr_pick and hps_request_arbiter.
package hps_req_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POST,
    DRAIN
  } state_t;

  localparam int MAX_REQ   = 8;
  localparam int ID_W      = 3;
  localparam int SEQ_W     = 6;
  localparam int PAY_W     = 16;
  localparam int VALID_BIT = 31;
  localparam int TMO_BIT   = 30;
  localparam int SEQ_LSB   = 24;
  localparam int ID_LSB    = 16;

  function automatic logic [ID_W-1:0] wrap_inc(
    input logic [ID_W-1:0] v,
    input int              n
  );
    if (int'(v) + 1 >= n) return '0;
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/hps_req_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr.
// Rotates a doubled request vector so the wrap needs no special case.
module hps_req_rr_pick
  import hps_req_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  localparam int DW = 2 * NUM_REQ;

  logic [DW-1:0]   rot;
  logic [ID_W:0]   off;
  logic [ID_W+1:0] sum;

  always_comb begin
    rot = {req, req} >> rr_ptr;
    off = '0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (rot[i]) off = (ID_W + 1)'(i);
    end
    sum = {2'b00, rr_ptr} + {1'b0, off};
    if (int'(sum) >= NUM_REQ) begin
      sum = sum - (ID_W + 2)'(NUM_REQ);
    end
    any    = |req;
    winner = sum[ID_W-1:0];
  end

endmodule

// File: rtl/hps_request_arbiter.sv
// Round-robin request poster for the HPS_REQUEST PIO, 4-phase ack.
// Optional POST timeout compiled in with HPS_REQ_TIMEOUT_EN.
module hps_request_arbiter
  import hps_req_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PAYLOAD_W      = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   payload,
  input  logic                           hps_ack,
  output logic [31:0]                    status_word,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             tmo,
  output logic                           irq
);

  if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_num
    $error("NUM_REQ out of range");
  end
  if (PAYLOAD_W < 1 || PAYLOAD_W > PAY_W) begin : g_bad_pay
    $error("PAYLOAD_W out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be positive");
  end

  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [SEQ_W-1:0]     seq_q, seq_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [PAY_W-1:0]     pay_q, pay_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 tmo_flag;

  logic                 any;
  logic [ID_W-1:0]      win;
  logic [PAY_W-1:0]     pay_sel;
  logic [NUM_REQ-1:0]   id_hot;

  hps_req_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (any),
    .winner (win)
  );

  always_comb begin
    pay_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        pay_sel[PAYLOAD_W-1:0] =
          payload[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      id_hot[i] = (id_q == ID_W'(i));
    end
  end

`ifdef HPS_REQ_TIMEOUT_EN
  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tflag_q, tflag_d;
  logic [NUM_REQ-1:0] tmo_q, tmo_d;

  assign tmo_flag = tflag_q;
  assign tmo      = tmo_q;
`else
  assign tmo_flag = 1'b0;
  assign tmo      = '0;
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    seq_d    = seq_q;
    id_d     = id_q;
    pay_d    = pay_q;
    rr_ptr_d = rr_ptr_q;
    done_d   = '0;
`ifdef HPS_REQ_TIMEOUT_EN
    cnt_d    = cnt_q;
    tflag_d  = tflag_q;
    tmo_d    = '0;
`endif
    unique case (state_q)
      IDLE: begin
        // A still-high ack belongs to the previous post.
        if (any && !hps_ack) begin
          id_d     = win;
          pay_d    = pay_sel;
          valid_d  = 1'b1;
          seq_d    = seq_q + 1'b1;
          rr_ptr_d = wrap_inc(win, NUM_REQ);
          state_d  = POST;
`ifdef HPS_REQ_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      POST: begin
        if (hps_ack) begin
          valid_d = 1'b0;
          done_d  = id_hot;
          state_d = DRAIN;
`ifdef HPS_REQ_TIMEOUT_EN
          tflag_d = 1'b0;
        end else if (cnt_q == CNT_LIM) begin
          valid_d = 1'b0;
          tflag_d = 1'b1;
          tmo_d   = id_hot;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DRAIN: begin
        if (!hps_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      seq_q    <= '0;
      id_q     <= '0;
      pay_q    <= '0;
      rr_ptr_q <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      seq_q    <= seq_d;
      id_q     <= id_d;
      pay_q    <= pay_d;
      rr_ptr_q <= rr_ptr_d;
      done_q   <= done_d;
    end
  end

`ifdef HPS_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      tflag_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
      tmo_q   <= tmo_d;
    end
  end
`endif

  always_comb begin
    status_word                          = '0;
    status_word[VALID_BIT]               = valid_q;
    status_word[TMO_BIT]                 = tmo_flag;
    status_word[SEQ_LSB +: SEQ_W]        = seq_q;
    status_word[ID_LSB +: ID_W]          = id_q;
    status_word[PAY_W-1:0]               = pay_q;
  end

  assign done = done_q;
  assign irq  = valid_q;

endmodule

// File: tb/tb_hps_request_arbiter.sv
// Directed bench for hps_request_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
// Covers both builds; timeout checks follow HPS_REQ_TIMEOUT_EN.
module tb_hps_request_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] payload = '0;
  logic        hps_ack = 1'b0;
  logic [31:0] status_word;
  logic [3:0]  done;
  logic [3:0]  tmo;
  logic        irq;

  int total = 0;
  int bad   = 0;

  hps_request_arbiter #(
    .NUM_REQ        (4),
    .PAYLOAD_W      (16),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .payload     (payload),
    .hps_ack     (hps_ack),
    .status_word (status_word),
    .done        (done),
    .tmo         (tmo),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hs(
    input int          id,
    input int          seq,
    input logic [15:0] pl
  );
    int n;
    n = 0;
    while (!status_word[31] && n < 20) begin
      tick();
      n++;
    end
    chk("post_valid", 32'(status_word[31]), 32'd1);
    chk("post_irq", 32'(irq), 32'd1);
    chk("post_id", 32'(status_word[18:16]), 32'(id));
    chk("post_seq", 32'(status_word[29:24]), 32'(seq));
    chk("post_pay", 32'(status_word[15:0]), 32'(pl));
    hps_ack = 1'b1;
    tick();
    chk("done", 32'(done), 32'(1 << id));
    chk("ack_valid", 32'(status_word[31]), 32'd0);
    chk("ack_id", 32'(status_word[18:16]), 32'(id));
    chk("ack_tmo", 32'(tmo), 32'd0);
    hps_ack = 1'b0;
    tick();
    chk("done_1cyc", 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_status", status_word, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    tick();
    tick();
    chk("rst_hold", status_word, 32'd0);
    chk("rst_hold_d", 32'(done | tmo), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    int seen;
    tick();
    chk("reset_status", status_word, 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("idle_status", status_word, 32'd0);

    // single request
    payload[47:32] = 16'hBEEF;
    req = 4'b0100;
    tick();
    chk("single_post", status_word, 32'h8102BEEF);
    tick();
    chk("single_hold", status_word, 32'h8102BEEF);
    hps_ack = 1'b1;
    tick();
    chk("single_done", 32'(done), 32'h4);
    chk("single_clr", status_word, 32'h0102BEEF);
    req = 4'b0000;
    hps_ack = 1'b0;
    tick();
    chk("single_done1", 32'(done), 32'd0);

    // round robin from a clean pointer
    do_reset();
    payload = 64'h4444_3333_2222_1111;
    req = 4'b1111;
    do_hs(0, 1, 16'h1111);
    do_hs(1, 2, 16'h2222);
    do_hs(2, 3, 16'h3333);
    do_hs(3, 4, 16'h4444);
    req = 4'b0001;
    hps_ack = 1'b1;

    // stale ack blocks arbitration
    repeat (3) tick();
    chk("stale_block", 32'(status_word[31]), 32'd0);
    hps_ack = 1'b0;
    req = 4'b1111;
    tick();
    chk("stale_post", 32'(status_word[31]), 32'd1);
    do_hs(0, 5, 16'h1111);

    // timeout path; rr_ptr now 1
    req = 4'b0010;
    tick();
    chk("to_post", status_word, 32'h8601_2222);
    seen = 0;
`ifdef HPS_REQ_TIMEOUT_EN
    repeat (15) begin
      tick();
      if (tmo != 0) seen++;
    end
    chk("to_early", 32'(seen), 32'd0);
    chk("to_early_v", 32'(status_word[31]), 32'd1);
    tick();
    chk("to_tmo", 32'(tmo), 32'h2);
    chk("to_word", status_word, 32'h4601_2222);
    chk("to_done", 32'(done), 32'd0);
    req = 4'b0000;
    tick();
    chk("to_tmo1", 32'(tmo), 32'd0);
    chk("to_sticky", 32'(status_word[30]), 32'd1);
    req = 4'b0001;
    tick();
    chk("to_sticky_p", 32'(status_word[31:30]), 32'd3);
    do_hs(0, 7, 16'h1111);
    chk("to_cleared", 32'(status_word[30]), 32'd0);
`else
    repeat (40) begin
      tick();
      if (tmo != 0 || status_word[30]) seen++;
    end
    chk("noto_quiet", 32'(seen), 32'd0);
    chk("noto_valid", 32'(status_word[31]), 32'd1);
    do_hs(1, 6, 16'h2222);
`endif
    req = 4'b0000;
    tick();

    // reset in the middle of POST
    req = 4'b0100;
    tick();
    chk("rp_post", 32'(status_word[31]), 32'd1);
    do_reset();
    req = 4'b0101;
    do_hs(0, 1, 16'h1111);
    req = 4'b0000;
    tick();

    // sequence wrap
    do_reset();
    req = 4'b0001;
    for (int i = 1; i <= 64; i++) begin
      do_hs(0, i % 64, 16'h1111);
    end
    req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
